// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
//
// Up/down counter that wraps inside a run-time programmable window [MIN, MAX].
// The window bounds, direction and run/stop control are sampled directly on
// every rising clock edge; the count itself is the only state and is driven
// out of a register.
//
// Ports
//   clk   in   system clock, all updates on the rising edge
//   rst   in   asynchronous active-high reset, forces OUT to 0 immediately
//   SS    in   1 = advance on each edge, 0 = hold
//   MODE  in   1 = count up, 0 = count down
//   MIN   in   WIDTH-bit lower bound of the window (inclusive)
//   MAX   in   WIDTH-bit upper bound of the window (inclusive)
//   OUT   out  WIDTH-bit registered count
// -----------------------------------------------------------------------------
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS,
  input  logic             MODE,
  input  logic [WIDTH-1:0] MIN,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] OUT
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // A window holding at most one value (MIN == MAX) or an inverted one
  // (MIN > MAX) has nothing to count through, so the output just pins to MIN.
  logic degenerate;
  logic in_window;
  logic at_max;
  logic at_min;

  assign degenerate = (MIN >= MAX);
  assign in_window  = (count_reg >= MIN) && (count_reg <= MAX);
  assign at_max     = (count_reg == MAX);
  assign at_min     = (count_reg == MIN);

  // Wrapping is decided purely by the window bounds; the +1/-1 below is never
  // reached at the natural WIDTH-bit limits because MAX/MIN catch them first
  // (count_reg == all-ones implies at_max whenever it is in the window, and
  // count_reg == 0 likewise implies at_min).
  always_comb begin
    count_next = count_reg;
    if (SS) begin
      if (degenerate) begin
        count_next = MIN;
      end else if (!in_window) begin
        // Re-enter the window at the end we are about to count away from.
        count_next = MODE ? MIN : MAX;
      end else if (MODE) begin
        count_next = at_max ? MIN : count_reg + 1'b1;
      end else begin
        count_next = at_min ? MAX : count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign OUT = count_reg;

endmodule

// File: tb/tb_counter.sv
module tb_counter;

  logic       clk;
  logic       rst;
  logic       SS;
  logic       MODE;
  logic [3:0] MIN;
  logic [3:0] MAX;
  logic [3:0] OUT;

  counter #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .SS   (SS),
    .MODE (MODE),
    .MIN  (MIN),
    .MAX  (MAX),
    .OUT  (OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Expected OUT after each upcoming rising edge, in edge order.
  logic [3:0] exp_q[$];

  // Reference model's view of the count.
  int model_out = 0;

  // Next count from the window rules, using modular arithmetic over the
  // window length rather than explicit compare-and-wrap.
  function automatic int ref_next(int cur, bit ss, bit mode, int mn, int mx);
    int len;
    if (!ss) return cur;
    if (mn >= mx) return mn;
    if (cur < mn || cur > mx) return mode ? mn : mx;
    len = mx - mn + 1;
    if (mode) return mn + ((cur - mn + 1) % len);
    return mn + ((cur - mn - 1 + len) % len);
  endfunction

  // Monitor: one expected value per rising edge while the queue holds any.
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (OUT !== e) begin
        miscompares++;
        $display("FAIL edge_out t=%0t got=%0d want=%0d", $time, OUT, e);
      end
    end
  end

  // Drive one edge's inputs (called at posedge+2). want < 0 lets the model
  // decide; otherwise the explicit value from the test plan is expected.
  task automatic apply(input bit ss, input bit mode, input int mn, input int mx,
                       input int want);
    int e;
    SS   = ss;
    MODE = mode;
    MIN  = 4'(mn);
    MAX  = 4'(mx);
    e = ref_next(model_out, ss, mode, mn, mx);
    if (want >= 0) e = want;
    model_out = e;
    exp_q.push_back(4'(e));
    @(posedge clk);
    #2;
  endtask

  task automatic seq(input bit mode, input int mn, input int mx, input int wants[]);
    foreach (wants[i]) apply(1'b1, mode, mn, mx, wants[i]);
  endtask

  task automatic check_now(input string name, input int want);
    vectors++;
    if (OUT !== 4'(want)) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, OUT, want);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges (entered at posedge+2).
  task automatic reset_pulse();
    #1 rst = 1'b1;
    #1 check_now("async_reset", 0);
    #1 rst = 1'b0;
    model_out = 0;
  endtask

  initial begin
    int budget;
    rst  = 1'b1;
    SS   = 1'b1;
    MODE = 1'b1;
    MIN  = 4'd1;
    MAX  = 4'd7;
    repeat (3) @(posedge clk);
    #2;
    check_now("reset_hold", 0);
    rst = 1'b0;
    model_out = 0;

    // Release and up count through the wrap, then on to 4.
    seq(1'b1, 1, 7, '{1, 2, 3, 4, 5, 6, 7, 1, 2, 3, 4});
    // Direction reversal at 4.
    seq(1'b0, 1, 7, '{3, 2, 1, 7, 6});
    // Hold at 6 for ten edges, MODE/bounds irrelevant while stopped.
    for (int i = 0; i < 10; i++) apply(1'b0, i[0], 0, 15, 6);
    apply(1'b1, 1'b0, 1, 7, 5);
    // Single-value and inverted windows.
    seq(1'b1, 9, 9, '{9, 9, 9});
    seq(1'b0, 10, 3, '{10, 10});
    // Full window: up across 15->0, then down across 0->15.
    seq(1'b1, 0, 15, '{11, 12, 13, 14, 15, 0, 1});
    seq(1'b0, 0, 15, '{0, 15});
    // Out-of-window resync, up direction.
    seq(1'b1, 1, 7, '{1, 2, 3, 4, 5, 6});
    apply(1'b1, 1'b1, 1, 4, 1);
    // Out-of-window resync, down direction.
    seq(1'b1, 1, 7, '{2, 3, 4, 5, 6});
    apply(1'b1, 1'b0, 1, 4, 4);
    // Async reset mid-count, then resync up.
    seq(1'b1, 1, 7, '{5});
    reset_pulse();
    apply(1'b1, 1'b1, 1, 7, 1);
    // Async reset mid-count, then resync down.
    seq(1'b1, 1, 7, '{2, 3, 4, 5});
    reset_pulse();
    apply(1'b1, 1'b0, 1, 7, 7);

    // Randomized traffic against the model.
    begin
      int mn, mx;
      mn = 2; mx = 12;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          mn = $urandom_range(0, 15);
          mx = $urandom_range(0, 15);
          if ($urandom_range(0, 3) != 0 && mn > mx) begin
            int t;
            t = mn; mn = mx; mx = t;
          end
        end
        if ($urandom_range(0, 63) == 0) reset_pulse();
        apply($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, mn, mx, -1);
      end
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Synchronous 4-bit up/down counter that wraps within a run-time programmable window [MIN, MAX].
- Controlled by a run/stop enable (SS) and a direction select (MODE).
- General-purpose sequencing/timing element, clocked by the system clock.
- Output is registered.

Parameters:
- WIDTH, 4, bit width of MIN, MAX and OUT. All arithmetic is unsigned at this width.

Ports:
- clk   input   1      system clock; all state changes on the rising edge
- rst   input   1      asynchronous, active-high reset
- SS    input   1      start/stop: 1 = count on each clk edge, 0 = hold
- MODE  input   1      direction: 1 = count up, 0 = count down
- MIN   input   WIDTH  lower bound of count window (inclusive), unsigned
- MAX   input   WIDTH  upper bound of count window (inclusive), unsigned
- OUT   output  WIDTH  current count, registered

Behaviour:
- Reset: rst=1 forces OUT=0 immediately, independent of clk. While rst=1, OUT stays 0.
- Release: after rst deasserts, the first rising edge with SS=1 applies the normal update rules.
- All updates occur on the clk rising edge when rst=0.
- MIN, MAX, MODE and SS are sampled at that edge. There is no input registering, so latency from input change to effect is one edge.
- SS=0: OUT holds its value, regardless of MODE, MIN or MAX.
- SS=1, degenerate window (MIN > MAX): OUT <= MIN every edge.
- SS=1, MIN == MAX: OUT <= MIN every edge.
- SS=1, OUT outside [MIN, MAX] (includes the post-reset value 0 when MIN > 0):
  - MODE=1: OUT <= MIN.
  - MODE=0: OUT <= MAX.
  - This resynchronisation takes one edge. Normal counting resumes on the next edge.
- SS=1, MODE=1 (up), OUT in window:
  - OUT < MAX: OUT <= OUT+1.
  - OUT == MAX: OUT <= MIN (wrap).
- SS=1, MODE=0 (down), OUT in window:
  - OUT > MIN: OUT <= OUT-1.
  - OUT == MIN: OUT <= MAX (wrap).
- No natural WIDTH-bit overflow/underflow is ever produced: wrap is purely window-based. The full window MIN=0, MAX=15 wraps 15->0 (up) and 0->15 (down).
- MODE change mid-count: takes effect on the next edge from the current value, with no skipped or repeated state beyond the direction reversal. Example: up at 5, MODE->0, next value is 4.
- MIN/MAX change mid-count:
  - If OUT is still inside the new window, counting continues.
  - If it falls outside, the resync rule applies on the next enabled edge.
- Asynchronous reset mid-count: OUT goes to 0 at once. After release, the resync rule applies.
- SS and MODE changing on the same edge: both take effect together. SS=0 dominates, so no count occurs.

Test Plan:
- Reset/start: MIN=1, MAX=7, SS=1, MODE=1, rst=1 then released. Required: OUT=0 during reset; first edge after release gives OUT=1; then 2,3,4,5,6,7,1,2 on successive edges.
- Down count: same window, counting up to OUT=4, then MODE->0. Required: 3,2,1,7,6,5 on successive edges.
- Hold: while counting down at OUT=6, SS->0 for 10 edges. Required: OUT stays 6. With SS->1 again, the next value is 5.
- Window edge cases:
  - MIN=MAX=9, SS=1: OUT=9 constant.
  - MIN=10, MAX=3: OUT=10 constant.
  - MIN=0, MAX=15, up from 14: 15, 0, 1.
  - Down from 1: 0, 15.
- Out-of-window resync: counting up at OUT=6, MAX changed to 4. Required: next edge gives OUT=MIN (1). With MODE=0 instead, next edge gives OUT=4.
- Async reset mid-count: rst pulsed between clk edges at OUT=5. Required: OUT=0 immediately, without waiting for a clock edge. The first enabled edge after release gives OUT=MIN (up) or MAX (down).
